modsub_serial: RTL and testbench
================================

Name: modsub_serial

Overview:
Multi-cycle modular subtractor. Computes result = (a - b) mod p over N-bit operands by streaming W-bit limbs through one shared limb adder/subtractor. The first pass subtracts; a second pass adds p back only when the first pass borrows. It is the subtract-side companion to the team's 256-bit adders in the field-arithmetic datapath, and trades latency for area compared with a full-width carry chain.

Parameters:
N, 256, operand/result width in bits
W, 32, limb width; N % W == 0 enforced by elaboration-time assertion
L, N/W (derived localparam), limb count

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands a, b, p present
in_ready  output  1  block can accept operands
a  input  N  minuend, must satisfy a < p
b  input  N  subtrahend, must satisfy b < p
p  input  N  modulus
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  N  (a - b) mod p
underflow  output  1  first pass borrowed (a < b)

Behaviour:
- Interface: one clock clk; reset rst_n is asynchronous, active-low.
- Reset (asynchronous assert, synchronous deassert): state=IDLE; limb index=0; carry/borrow=0; operand and result registers=0; in_ready=1; out_valid=0; result=0; underflow=0.
- FSM states: IDLE, SUB, ADDBACK, DONE.
- IDLE: in_ready=1. When in_valid&&in_ready at a clock edge:
  - capture a, b and p;
  - clear the borrow and index;
  - go to SUB.
- SUB: one limb per cycle.
  - res[i] = a[i] - b[i] - borrow (mod 2^W); borrow = 1 when a[i] < b[i] + borrow.
  - On i==L-1, latch underflow = final borrow.
  - If the final borrow is 1: go to ADDBACK with carry=0, i=0. Otherwise go to DONE.
- ADDBACK: one limb per cycle.
  - res[i] = res[i] + p[i] + carry (mod 2^W).
  - The final carry-out is discarded; it is always 1 for legal inputs.
  - On i==L-1, go to DONE.
- DONE: out_valid=1; result and underflow are held stable.
  - When out_valid&&out_ready, go to IDLE; out_valid drops on the next cycle.
- in_ready=1 only in IDLE. There is no overlap of operations; in_valid is ignored outside IDLE.
- Latency, counted from the accept edge to the first cycle with out_valid high: L cycles if there is no underflow, 2L cycles with ADDBACK. With the defaults that is 8 or 16 cycles.
- result is registered and changes only during SUB/ADDBACK. It is not guaranteed meaningful until out_valid.
- Operands are sampled only at acceptance; input changes afterwards have no effect.
- Out-of-range inputs (a>=p or b>=p): the block still completes with the same latency. The result equals the raw two-pass arithmetic and is not reduced.
- Reset mid-operation: the operation is aborted immediately; all outputs return to their reset values; nothing is emitted.
- Simultaneous out_ready during the first DONE cycle: a completion in one cycle is legal.

Decomposition:
- Package modsub_pkg:
  - state enum typedef (IDLE, SUB, ADDBACK, DONE);
  - limb-count helper function;
  - default N/W constants.
- Sub-module limb_addsub #(W):
  - combinational W-bit adder/subtractor;
  - inputs x, y, cin, sub;
  - subtraction is implemented as x + ~y + ~borrow;
  - outputs s and cout.
  - modsub_serial instantiates it once and muxes operands by state.

Test Plan:
- Simple subtract: p=2^255-19, a=10, b=3 -> result=7, underflow=0, out_valid exactly 8 cycles after accept.
- Wrap with add-back: same p, a=3, b=10 -> result=2^255-26, underflow=1, latency 16 cycles.
- Full borrow chain: a=0, b=1 -> result=p-1 (borrow through all 8 limbs, then add-back), underflow=1. Also a=2^32, b=1 -> result=0xFFFFFFFF, underflow=0.
- Equal operands: a=b=p-1 -> result=0, underflow=0, no ADDBACK (latency 8).
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid with new operands -> result, underflow and out_valid stay stable; in_ready=0; new operands ignored. Release -> IDLE next cycle; the next accepted op is correct.
- Reset mid-SUB: assert rst_n=0 on the 3rd SUB cycle -> out_valid=0, result=0, underflow=0, in_ready=1 immediately. After release, a=5, b=9 -> result=p-4, underflow=1.

Source files
------------

// File: rtl/modsub_pkg.sv
// rtl/modsub_pkg.sv - shared types and constants for the serial modular subtractor
package modsub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SUB,
    ADDBACK,
    DONE
  } state_t;

  localparam int N_DEFAULT = 256;
  localparam int W_DEFAULT = 32;

  function automatic int limb_count(input int n, input int w);
    return n / w;
  endfunction

endpackage

// File: rtl/limb_addsub.sv
// rtl/limb_addsub.sv - combinational W-bit limb adder/subtractor
// For sub=1, cin/cout carry borrow semantics: s = x - y - cin, computed as x + ~y + ~cin.
module limb_addsub #(
  parameter int W = 32
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         cin,
  input  logic         sub,
  output logic [W-1:0] s,
  output logic         cout
);

  logic [W-1:0] y_eff;
  logic         c_eff;
  logic [W:0]   sum;

  assign y_eff = sub ? ~y : y;
  assign c_eff = sub ? ~cin : cin;
  assign sum   = {1'b0, x} + {1'b0, y_eff} + {{W{1'b0}}, c_eff};
  assign s     = sum[W-1:0];
  assign cout  = sub ? ~sum[W] : sum[W];

endmodule

// File: rtl/modsub_serial.sv
// rtl/modsub_serial.sv - multi-cycle (a - b) mod p, one W-bit limb per cycle
// First pass subtracts; a second pass adds p back only when the first pass borrows.
module modsub_serial
  import modsub_pkg::*;
#(
  parameter int N = N_DEFAULT,
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] p,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         underflow
);

  localparam int L  = limb_count(N, W);
  localparam int IW = (L > 1) ? $clog2(L) : 1;
  localparam logic [IW-1:0] LAST = IW'(L - 1);

  if (N % W != 0) begin : g_width_check
    $error("modsub_serial: N must be a multiple of W");
  end

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          cb_q, cb_d;
  logic [N-1:0]  a_q, a_d, b_q, b_d, p_q, p_d, res_q, res_d;
  logic          underflow_q, underflow_d;
  logic          out_valid_q, out_valid_d;
  logic          in_ready_q, in_ready_d;

  logic          sub_sel;
  logic [W-1:0]  x_limb, y_limb, s_limb;
  logic          cout;

  // The single limb unit reads a/b in SUB and res/p in ADDBACK.
  assign sub_sel = (state_q == SUB);
  assign x_limb  = sub_sel ? a_q[idx_q*W +: W] : res_q[idx_q*W +: W];
  assign y_limb  = sub_sel ? b_q[idx_q*W +: W] : p_q[idx_q*W +: W];

  limb_addsub #(.W(W)) u_limb (
    .x    (x_limb),
    .y    (y_limb),
    .cin  (cb_q),
    .sub  (sub_sel),
    .s    (s_limb),
    .cout (cout)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cb_d        = cb_q;
    a_d         = a_q;
    b_d         = b_q;
    p_d         = p_q;
    res_d       = res_q;
    underflow_d = underflow_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d        = a;
          b_d        = b;
          p_d        = p;
          idx_d      = '0;
          cb_d       = 1'b0;
          in_ready_d = 1'b0;
          state_d    = SUB;
        end
      end
      SUB: begin
        res_d[idx_q*W +: W] = s_limb;
        cb_d                = cout;
        if (idx_q == LAST) begin
          underflow_d = cout;
          idx_d       = '0;
          if (cout) begin
            cb_d    = 1'b0;
            state_d = ADDBACK;
          end else begin
            out_valid_d = 1'b1;
            state_d     = DONE;
          end
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      ADDBACK: begin
        // Final carry-out is dropped: it only cancels the wrap from the first pass.
        res_d[idx_q*W +: W] = s_limb;
        cb_d                = cout;
        if (idx_q == LAST) begin
          idx_d       = '0;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cb_q        <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      p_q         <= '0;
      res_q       <= '0;
      underflow_q <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cb_q        <= cb_d;
      a_q         <= a_d;
      b_q         <= b_d;
      p_q         <= p_d;
      res_q       <= res_d;
      underflow_q <= underflow_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = res_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_modsub_serial.sv
// tb/tb_modsub_serial.sv - table-driven, scoreboarded bench for modsub_serial
module tb_modsub_serial;

  localparam int N = 256;
  localparam logic [N-1:0] P = {1'b0, {255{1'b1}}} - 256'd18;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] p;
    logic [N-1:0] res;
    logic         uf;
    int           lat;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] a_i = '0, b_i = '0, p_i = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [N-1:0] result;
  logic         underflow;

  int n_checks = 0;
  int n_pass = 0;
  vec_t sb[$];
  vec_t vecs[$];

  always #5 clk = ~clk;

  modsub_serial #(.N(N), .W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a_i),
    .b         (b_i),
    .p         (p_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .underflow (underflow)
  );

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  function automatic vec_t model(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] p);
    vec_t v;
    v.a = a; v.b = b; v.p = p;
    v.uf  = (a < b);
    v.res = v.uf ? (a - b + p) : (a - b);
    v.lat = v.uf ? 16 : 8;
    return v;
  endfunction

  function automatic vec_t mk(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] p,
                              input logic [N-1:0] res, input logic uf, input int lat);
    vec_t v;
    v.a = a; v.b = b; v.p = p; v.res = res; v.uf = uf; v.lat = lat;
    return v;
  endfunction

  task automatic start_op(input vec_t v);
    int w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    check("in_ready_before_accept", {255'd0, in_ready}, 256'd1);
    a_i = v.a; b_i = v.b; p_i = v.p; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    sb.push_back(v);
  endtask

  task automatic finish_op(input string name);
    int lat = 0;
    vec_t e;
    while (!out_valid && lat < 64) begin
      @(posedge clk); #1; lat++;
    end
    if (!out_valid) begin
      check({name, "_timeout"}, 256'd0, 256'd1);
      return;
    end
    if (sb.size() == 0) begin
      check({name, "_unexpected_output"}, 256'd1, 256'd0);
      return;
    end
    e = sb.pop_front();
    check({name, "_result"}, result, e.res);
    check({name, "_underflow"}, {255'd0, underflow}, {255'd0, e.uf});
    check({name, "_latency"}, N'(lat), N'(e.lat));
  endtask

  task automatic run_op(input vec_t v, input string name);
    out_ready = 1'b1;
    start_op(v);
    finish_op(name);
    @(posedge clk); #1;
    check({name, "_out_valid_drop"}, {255'd0, out_valid}, 256'd0);
  endtask

  initial begin
    logic [N-1:0] ra, rb, held_res;
    logic held_uf;

    vecs.push_back(mk(256'd10, 256'd3, P, 256'd7, 1'b0, 8));
    vecs.push_back(mk(256'd3, 256'd10, P, P - 256'd7, 1'b1, 16));
    vecs.push_back(mk(256'd0, 256'd1, P, P - 256'd1, 1'b1, 16));
    vecs.push_back(mk(256'h1_0000_0000, 256'd1, P, 256'hFFFF_FFFF, 1'b0, 8));
    vecs.push_back(mk(P - 256'd1, P - 256'd1, P, 256'd0, 1'b0, 8));
    vecs.push_back(mk(P, 256'd0, P, P, 1'b0, 8));
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 8; k++) begin
        ra[k*32 +: 32] = $urandom;
        rb[k*32 +: 32] = $urandom;
      end
      ra[255] = 1'b0; rb[255] = 1'b0;
      if (ra >= P) ra = ra - P;
      if (rb >= P) rb = rb - P;
      vecs.push_back(model(ra, rb, P));
    end

    #12;
    check("reset_in_ready", {255'd0, in_ready}, 256'd1);
    check("reset_out_valid", {255'd0, out_valid}, 256'd0);
    check("reset_result", result, 256'd0);
    check("reset_underflow", {255'd0, underflow}, 256'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
    end

    // Backpressure in DONE with in_valid toggling and new operands ignored.
    out_ready = 1'b0;
    start_op(vecs[1]);
    finish_op("bp");
    held_res = result;
    held_uf  = underflow;
    for (int c = 0; c < 5; c++) begin
      in_valid = ~in_valid;
      a_i = {8{$urandom}}; b_i = {8{$urandom}};
      @(posedge clk); #1;
      check("bp_result_hold", result, held_res);
      check("bp_underflow_hold", {255'd0, underflow}, {255'd0, held_uf});
      check("bp_out_valid_hold", {255'd0, out_valid}, 256'd1);
      check("bp_in_ready_low", {255'd0, in_ready}, 256'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_out_valid", {255'd0, out_valid}, 256'd0);
    check("bp_release_in_ready", {255'd0, in_ready}, 256'd1);
    run_op(vecs[0], "after_bp");

    // Reset on the third SUB cycle aborts the operation.
    start_op(vecs[2]);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    sb.delete();
    check("rst_out_valid", {255'd0, out_valid}, 256'd0);
    check("rst_result", result, 256'd0);
    check("rst_underflow", {255'd0, underflow}, 256'd0);
    check("rst_in_ready", {255'd0, in_ready}, 256'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(mk(256'd5, 256'd9, P, P - 256'd4, 1'b1, 16), "after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
